// File: rtl/acc_buffer_pkg.sv
// Shared widths, saturation limits and state encodings for the ping-pong accumulation buffer.
package acc_buffer_pkg;
    localparam int ACC_W    = 24;
    localparam int LANES    = 16;
    localparam int ROWS     = 16;
    localparam int ROW_W    = $clog2(ROWS);
    localparam int ROW_BITS = ACC_W * LANES;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } drain_state_e;
endpackage

// File: rtl/acc_buffer_sat_add.sv
// One accumulator lane: either passes the new psum through (first K-tile) or adds it
// to the stored value with signed saturation, flagging any clamp.
module acc_buffer_sat_add
    import acc_buffer_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             first,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);
    logic [ACC_W:0] wide;
    logic           overflow;

    // One guard bit is enough: overflow shows up as the two top bits disagreeing.
    always_comb begin
        wide     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        overflow = wide[ACC_W] != wide[ACC_W-1];
        sat      = !first && overflow;
        if (first) begin
            sum = b;
        end else if (overflow) begin
            sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            sum = wide[ACC_W-1:0];
        end
    end
endmodule

// File: rtl/acc_buffer.sv
// Ping-pong accumulation buffer: the array accumulates K-tiles into one bank while the
// other bank streams a finished 16x16 tile to the ppu behind a one-cycle start pulse.
module acc_buffer
    import acc_buffer_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_psum_valid,
    output logic                o_psum_ready,
    input  logic [ROW_BITS-1:0] i_psum_data,
    input  logic                i_psum_first,
    input  logic                i_psum_last,
    input  logic                i_ppu_stall,
    input  logic                i_clr_sat,
    output logic                o_ppu_start,
    output logic [ROW_BITS-1:0] o_acc_data,
    output logic                o_acc_valid,
    output logic                o_sat
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic [ROW_BITS-1:0] mem [2][ROWS];
    bank_state_e         bank_st [2];
    drain_state_e        state;
    drain_state_e        state_nxt;
    logic                wr_bank;
    logic                rd_bank;
    logic [ROW_W-1:0]    wr_row;
    logic [ROW_W-1:0]    rd_row;
    logic                accept;
    logic                other_full;
    logic [ROW_BITS-1:0] acc_old;
    logic [ROW_BITS-1:0] acc_new;
    logic [LANES-1:0]    lane_sat;

    assign o_psum_ready = (bank_st[wr_bank] != FULL) && (bank_st[wr_bank] != DRAINING);
    assign accept       = i_psum_valid && o_psum_ready;
    assign acc_old      = mem[wr_bank][wr_row];
    assign other_full   = bank_st[~rd_bank] == FULL;
    assign o_ppu_start  = state == START;
    assign o_acc_valid  = state == STREAM;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        acc_buffer_sat_add u_sat_add (
            .a     (acc_old[g*ACC_W +: ACC_W]),
            .b     (i_psum_data[g*ACC_W +: ACC_W]),
            .first (i_psum_first),
            .sum   (acc_new[g*ACC_W +: ACC_W]),
            .sat   (lane_sat[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_bank][wr_row] <= acc_new;
        end
    end

    // Finishing a stream with the other bank already full skips the IDLE cycle,
    // which keeps back-to-back starts exactly 17 cycles apart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bank_st[rd_bank] == FULL && !i_ppu_stall) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                if (rd_row == LAST_ROW) begin
                    state_nxt = (other_full && !i_ppu_stall) ? START : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write and drain sides never touch the same bank in one cycle: the writer only
    // owns EMPTY/FILLING banks, the drainer only FULL/DRAINING ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_row     <= '0;
            rd_row     <= '0;
            o_acc_data <= '0;
            o_sat      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                wr_row <= wr_row + 1'b1;
                if (wr_row == LAST_ROW && i_psum_last) begin
                    bank_st[wr_bank] <= FULL;
                    wr_bank          <= ~wr_bank;
                end else begin
                    bank_st[wr_bank] <= FILLING;
                end
            end

            if (accept && |lane_sat) begin
                o_sat <= 1'b1;
            end else if (i_clr_sat) begin
                o_sat <= 1'b0;
            end

            case (state)
                IDLE: begin
                    o_acc_data <= '0;
                    rd_row     <= '0;
                    if (state_nxt == START) begin
                        bank_st[rd_bank] <= DRAINING;
                    end
                end
                START: begin
                    o_acc_data <= mem[rd_bank][ROW_W'(0)];
                    rd_row     <= '0;
                end
                STREAM: begin
                    if (rd_row == LAST_ROW) begin
                        o_acc_data       <= '0;
                        rd_row           <= '0;
                        bank_st[rd_bank] <= EMPTY;
                        rd_bank          <= ~rd_bank;
                        if (state_nxt == START) begin
                            bank_st[~rd_bank] <= DRAINING;
                        end
                    end else begin
                        o_acc_data <= mem[rd_bank][rd_row + 1'b1];
                        rd_row     <= rd_row + 1'b1;
                    end
                end
                default: begin
                    o_acc_data <= '0;
                    rd_row     <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_buffer.sv
// Directed bench for acc_buffer: table of saturation vectors plus hand-built sequences
// for streaming, accumulation, ping-pong, stall and mid-stream reset.
module tb_acc_buffer;
    import acc_buffer_pkg::*;

    localparam int DW = ROW_BITS;
    typedef logic [DW-1:0] row_t;

    typedef struct {
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] b;
        logic [ACC_W-1:0] exp_sum;
        logic             exp_sat;
    } sat_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic psum_valid = 1'b0;
    logic psum_first = 1'b0;
    logic psum_last = 1'b0;
    logic ppu_stall = 1'b0;
    logic clr_sat = 1'b0;
    row_t psum_data = '0;
    logic o_psum_ready;
    logic o_ppu_start;
    logic o_acc_valid;
    logic o_sat;
    row_t o_acc_data;

    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   stall_cnt = 0;
    int   idle_errs = 0;
    int   cyc = 0;
    row_t tile_buf[ROWS];
    row_t exp_q[$];
    row_t row_q[$];
    int   row_cyc_q[$];
    int   start_q[$];
    sat_vec_t vecs[8];

    acc_buffer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_psum_valid (psum_valid),
        .o_psum_ready (o_psum_ready),
        .i_psum_data  (psum_data),
        .i_psum_first (psum_first),
        .i_psum_last  (psum_last),
        .i_ppu_stall  (ppu_stall),
        .i_clr_sat    (clr_sat),
        .o_ppu_start  (o_ppu_start),
        .o_acc_data   (o_acc_data),
        .o_acc_valid  (o_acc_valid),
        .o_sat        (o_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: records start pulses and streamed rows with their cycle numbers.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ppu_start) start_q.push_back(cyc);
            if (o_acc_valid) begin
                row_q.push_back(o_acc_data);
                row_cyc_q.push_back(cyc);
            end
            if (!o_acc_valid && o_acc_data != '0) idle_errs++;
            if (o_ppu_start && o_acc_valid) idle_errs++;
        end
    end

    int   trk_row;
    logic trk_first;
    logic trk_last;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_row <= 0;
        end else if (psum_valid && o_psum_ready) begin
            if (trk_row == 0) begin
                trk_first <= psum_first;
                trk_last  <= psum_last;
            end else begin
                assert (psum_first == trk_first && psum_last == trk_last)
                    else $error("[TB] first/last flags changed inside a tile");
            end
            trk_row <= (trk_row == ROWS - 1) ? 0 : trk_row + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input row_t act, input row_t exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic row_t makeRow(input int base, input int r);
        row_t v = '0;
        for (int g = 0; g < LANES; g++) v[g*ACC_W +: ACC_W] = ACC_W'(base + r * LANES + g);
        return v;
    endfunction

    task automatic sendBeat(input row_t data, input logic first, input logic last);
        int waited = 0;
        psum_valid = 1'b1;
        psum_data  = data;
        psum_first = first;
        psum_last  = last;
        while (!o_psum_ready && waited < 200) begin
            @(negedge clk);
            waited++;
            stall_cnt++;
        end
        if (waited >= 200) checkOutput("beat_accept_timeout", row_t'(waited), row_t'(0));
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic first, input logic last);
        for (int r = 0; r < ROWS; r++) sendBeat(tile_buf[r], first, last);
    endtask

    task automatic fillTile(input int base);
        for (int r = 0; r < ROWS; r++) tile_buf[r] = makeRow(base, r);
    endtask

    task automatic fillConst(input logic [ACC_W-1:0] v);
        for (int r = 0; r < ROWS; r++) tile_buf[r] = {LANES{v}};
    endtask

    task automatic pushExpTile();
        for (int r = 0; r < ROWS; r++) exp_q.push_back(tile_buf[r]);
    endtask

    task automatic waitRows(input int n);
        int b = 0;
        while (row_q.size() < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clearQueues();
        row_q.delete();
        row_cyc_q.delete();
        start_q.delete();
        exp_q.delete();
    endtask

    // Compares every streamed row with the expected tiles, and each row's cycle with start+1+k.
    task automatic checkStream(input string name);
        int terr = 0;
        checkOutput({name, "_rows"}, row_t'(row_q.size()), row_t'(exp_q.size()));
        checkOutput({name, "_starts"}, row_t'(start_q.size()), row_t'(exp_q.size() / ROWS));
        for (int i = 0; i < exp_q.size() && i < row_q.size(); i++)
            checkOutput($sformatf("%s_row%0d", name, i), row_q[i], exp_q[i]);
        for (int i = 0; i < row_q.size(); i++) begin
            if (i / ROWS >= start_q.size()) terr++;
            else if (row_cyc_q[i] != start_q[i / ROWS] + 1 + (i % ROWS)) terr++;
        end
        checkOutput({name, "_timing"}, row_t'(terr), row_t'(0));
        clearQueues();
    endtask

    initial begin
        vecs[0] = '{24'h7FFFF0, 24'h000020, 24'h7FFFFF, 1'b1};
        vecs[1] = '{24'h800010, 24'hFFFFE0, 24'h800000, 1'b1};
        vecs[2] = '{24'h000005, 24'hFFFFF0, 24'hFFFFF5, 1'b0};
        vecs[3] = '{24'h123456, 24'h111111, 24'h234567, 1'b0};
        vecs[4] = '{24'hFFFFFF, 24'h800001, 24'h800000, 1'b0};
        vecs[5] = '{24'h7FFFFE, 24'h000001, 24'h7FFFFF, 1'b0};
        vecs[6] = '{24'h800000, 24'hFFFFFF, 24'h800000, 1'b1};
        vecs[7] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_start", row_t'(o_ppu_start), row_t'(0));
        checkOutput("reset_valid", row_t'(o_acc_valid), row_t'(0));
        checkOutput("reset_data", o_acc_data, row_t'(0));
        checkOutput("reset_sat", row_t'(o_sat), row_t'(0));
        checkOutput("reset_ready", row_t'(o_psum_ready), row_t'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Single K-tile streamed bit-exact
        fillTile(0);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        waitRows(16);
        checkStream("single");

        // Three K-tiles of +1
        fillConst(24'd1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        fillConst(24'd3);
        pushExpTile();
        waitRows(16);
        checkStream("accum3");

        // Saturation table
        for (int v = 0; v < 8; v++) begin
            clr_sat = 1'b1;
            @(negedge clk);
            clr_sat = 1'b0;
            checkOutput($sformatf("vec%0d_clr", v), row_t'(o_sat), row_t'(0));
            fillConst(vecs[v].a);
            applyStimulus(1'b1, 1'b0);
            fillConst(vecs[v].b);
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("vec%0d_sat", v), row_t'(o_sat), row_t'(vecs[v].exp_sat));
            fillConst(vecs[v].exp_sum);
            pushExpTile();
            waitRows(16);
            checkStream($sformatf("vec%0d", v));
        end

        // Saturation on the last beat while clear is requested: set wins
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        fillConst(24'h7FFFF0);
        applyStimulus(1'b1, 1'b0);
        for (int r = 0; r < ROWS - 1; r++) sendBeat(row_t'(0), 1'b0, 1'b1);
        checkOutput("setwin_before", row_t'(o_sat), row_t'(0));
        clr_sat = 1'b1;
        sendBeat({LANES{24'h000020}}, 1'b0, 1'b1);
        checkOutput("setwin_sat", row_t'(o_sat), row_t'(1));
        clr_sat = 1'b0;
        tile_buf[ROWS-1] = {LANES{24'h7FFFFF}};
        pushExpTile();
        waitRows(16);
        checkStream("setwin");
        clr_sat = 1'b1;
        @(negedge clk);
        clr_sat = 1'b0;
        checkOutput("setwin_clr", row_t'(o_sat), row_t'(0));

        // Ping-pong: A and B back to back, C waits for A's bank to free
        stall_cnt = 0;
        fillTile(24'h100000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        fillTile(24'h200000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        checkOutput("pp_ab_no_stall", row_t'(stall_cnt), row_t'(0));
        stall_cnt = 0;
        fillTile(24'h300000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        checkOutput("pp_c_stall_cycles", row_t'(stall_cnt), row_t'(2));
        waitRows(48);
        checkOutput("pp_spacing_ab", row_t'((start_q.size() >= 2) ? start_q[1] - start_q[0] : -1), row_t'(17));
        checkOutput("pp_spacing_bc", row_t'((start_q.size() >= 3) ? start_q[2] - start_q[1] : -1), row_t'(17));
        checkStream("pingpong");

        // Stall: full bank held off, then a stream that ignores a mid-stream stall
        ppu_stall = 1'b1;
        fillTile(24'h400000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("stall_no_start", row_t'(start_q.size()), row_t'(0));
        ppu_stall = 1'b0;
        begin
            int b = 0;
            while (start_q.size() < 1 && b < 50) begin
                @(negedge clk);
                b++;
            end
        end
        @(negedge clk);
        ppu_stall = 1'b1;
        fillTile(24'h500000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        waitRows(16);
        repeat (10) @(negedge clk);
        checkOutput("stall_stream_done", row_t'(row_q.size()), row_t'(16));
        checkOutput("stall_hold_second", row_t'(start_q.size()), row_t'(1));
        ppu_stall = 1'b0;
        waitRows(32);
        checkStream("stall");

        // Reset in the middle of a stream with the other bank partly filled
        fillTile(24'h600000);
        applyStimulus(1'b1, 1'b1);
        for (int r = 0; r < 5; r++) sendBeat(makeRow(24'h700000, r), 1'b1, 1'b1);
        begin
            int b = 0;
            while (!o_acc_valid && b < 50) begin
                @(negedge clk);
                b++;
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", row_t'(o_acc_valid), row_t'(0));
        checkOutput("rst_mid_data", o_acc_data, row_t'(0));
        checkOutput("rst_mid_start", row_t'(o_ppu_start), row_t'(0));
        checkOutput("rst_mid_ready", row_t'(o_psum_ready), row_t'(1));
        @(posedge clk);
        #1;
        checkOutput("rst_hold_valid", row_t'(o_acc_valid), row_t'(0));
        @(negedge clk);
        rst_n = 1'b1;
        clearQueues();
        repeat (30) @(negedge clk);
        checkOutput("rst_no_start", row_t'(start_q.size()), row_t'(0));
        fillTile(24'h080000);
        pushExpTile();
        applyStimulus(1'b1, 1'b1);
        waitRows(16);
        checkStream("after_reset");

        checkOutput("idle_data_zero", row_t'(idle_errs), row_t'(0));
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
